// File: rtl/mult_div_unit.sv
// mult_div_unit: multicycle signed multiply / divide unit feeding the HI/LO
// registers. Multiply uses radix-2 Booth recoding; divide uses restoring
// division on operand magnitudes followed by a sign-fix cycle.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             mult_start,
    input  logic             div_start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LastCount = CW'(WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        MULT,
        DIV,
        FIX,
        DONE
    } state_t;

    state_t state;
    state_t nextState;

    // Shared datapath: acc is the Booth accumulator or the division remainder,
    // mq is the multiplier or the dividend/quotient shift register, and
    // operand holds the multiplicand or the divisor magnitude.
    logic [WIDTH:0]   acc;
    logic [WIDTH-1:0] mq;
    logic             qm1;
    logic [WIDTH-1:0] operand;
    logic [CW-1:0]    count;
    logic             isDiv;
    logic             negQuot;
    logic             negRem;

    logic [WIDTH:0]   operandExt;
    logic [WIDTH:0]   boothSum;
    logic [WIDTH:0]   remShift;
    logic [WIDTH:0]   divTrial;
    logic [WIDTH-1:0] absA;
    logic [WIDTH-1:0] absB;

    assign operandExt = {operand[WIDTH-1], operand};
    assign absA       = a[WIDTH-1] ? (~a + 1'b1) : a;
    assign absB       = b[WIDTH-1] ? (~b + 1'b1) : b;

    // Booth step: add or subtract the sign-extended multiplicand depending on
    // the current multiplier bit pair, ahead of the arithmetic right shift.
    always_comb begin
        boothSum = acc;
        case ({mq[0], qm1})
            2'b01:   boothSum = acc + operandExt;
            2'b10:   boothSum = acc - operandExt;
            default: boothSum = acc;
        endcase
    end

    // Restoring division step: shift the next dividend bit into the remainder
    // and trial-subtract the divisor; a negative result means restore.
    always_comb begin
        remShift = {acc[WIDTH-1:0], mq[WIDTH-1]};
        divTrial = remShift - {1'b0, operand};
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state logic; multiply takes priority when both starts arrive together.
    always_comb begin
        nextState = state;
        case (state)
            IDLE: begin
                if (mult_start) begin
                    nextState = MULT;
                end else if (div_start) begin
                    nextState = (b == '0) ? DONE : DIV;
                end
            end
            MULT:    nextState = (count == LastCount) ? FIX : MULT;
            DIV:     nextState = (count == LastCount) ? FIX : DIV;
            FIX:     nextState = DONE;
            DONE:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Output decode straight from the state.
    always_comb begin
        busy = (state != IDLE);
        done = (state == DONE);
    end

    // Datapath: operand capture, per-cycle iteration and the final HI/LO write.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc      <= '0;
            mq       <= '0;
            qm1      <= 1'b0;
            operand  <= '0;
            count    <= '0;
            isDiv    <= 1'b0;
            negQuot  <= 1'b0;
            negRem   <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            div_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (mult_start) begin
                        acc      <= '0;
                        mq       <= b;
                        qm1      <= 1'b0;
                        operand  <= a;
                        count    <= '0;
                        isDiv    <= 1'b0;
                        div_zero <= 1'b0;
                    end else if (div_start) begin
                        if (b == '0) begin
                            div_zero <= 1'b1;
                        end else begin
                            acc      <= '0;
                            mq       <= absA;
                            qm1      <= 1'b0;
                            operand  <= absB;
                            count    <= '0;
                            isDiv    <= 1'b1;
                            negQuot  <= a[WIDTH-1] ^ b[WIDTH-1];
                            negRem   <= a[WIDTH-1];
                            div_zero <= 1'b0;
                        end
                    end
                end
                MULT: begin
                    acc   <= {boothSum[WIDTH], boothSum[WIDTH:1]};
                    mq    <= {boothSum[0], mq[WIDTH-1:1]};
                    qm1   <= mq[0];
                    count <= count + 1'b1;
                end
                DIV: begin
                    if (divTrial[WIDTH]) begin
                        acc <= remShift;
                    end else begin
                        acc <= divTrial;
                    end
                    mq    <= {mq[WIDTH-2:0], ~divTrial[WIDTH]};
                    count <= count + 1'b1;
                end
                FIX: begin
                    if (isDiv) begin
                        lo <= negQuot ? (~mq + 1'b1) : mq;
                        hi <= negRem ? (~acc[WIDTH-1:0] + 1'b1) : acc[WIDTH-1:0];
                    end else begin
                        hi <= acc[WIDTH-1:0];
                        lo <= mq;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: directed and randomized checks of mult_div_unit against a
// plain-arithmetic reference of signed multiply and truncating divide.
module tb_mult_div_unit;

    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             reset;
    logic             mult_start;
    logic             div_start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             done;
    logic             div_zero;

    int checks = 0;
    int errors = 0;

    logic [31:0] expHi = '0;
    logic [31:0] expLo = '0;
    logic        expDz = 1'b0;

    mult_div_unit #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .mult_start (mult_start),
        .div_start  (div_start),
        .a          (a),
        .b          (b),
        .hi         (hi),
        .lo         (lo),
        .busy       (busy),
        .done       (done),
        .div_zero   (div_zero)
    );

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Reference: mode 0 multiply, 1 divide, 2 both starts (multiply wins).
    task automatic modelOp(input int mode, input logic [31:0] av, input logic [31:0] bv);
        longint la;
        longint lb;
        longint res;
        la = longint'($signed(av));
        lb = longint'($signed(bv));
        if (mode != 1) begin
            res   = la * lb;
            expHi = res[63:32];
            expLo = res[31:0];
            expDz = 1'b0;
        end else if (bv == 32'd0) begin
            expDz = 1'b1;
        end else begin
            res   = la / lb;
            expLo = res[31:0];
            res   = la % lb;
            expHi = res[31:0];
            expDz = 1'b0;
        end
    endtask

    // Drive one start pulse that is accepted at the next rising edge (E0),
    // then scramble the operand inputs so late changes would be visible.
    task automatic applyStimulus(input int mode, input logic [31:0] av, input logic [31:0] bv);
        @(negedge clk);
        a          = av;
        b          = bv;
        mult_start = (mode != 1);
        div_start  = (mode != 0);
        @(posedge clk);
        #1;
        mult_start = 1'b0;
        div_start  = 1'b0;
        a          = $urandom;
        b          = $urandom;
    endtask

    // Wait (bounded) for done, checking latency, busy, results and the
    // single-cycle done pulse followed by return to idle.
    task automatic waitDone(input string tag, input int expCycles);
        int cycles = 0;
        bit busyOk = 1'b1;
        while (done !== 1'b1 && cycles < 60) begin
            if (busy !== 1'b1) busyOk = 1'b0;
            @(posedge clk);
            #1;
            cycles++;
        end
        if (busy !== 1'b1) busyOk = 1'b0;
        checkOutput({tag, "/cycles"}, 64'(cycles), 64'(expCycles));
        checkOutput({tag, "/busy"}, 64'(busyOk), 64'd1);
        checkOutput({tag, "/hi"}, 64'(hi), 64'(expHi));
        checkOutput({tag, "/lo"}, 64'(lo), 64'(expLo));
        checkOutput({tag, "/divzero"}, 64'(div_zero), 64'(expDz));
        @(posedge clk);
        #1;
        checkOutput({tag, "/donePulse"}, 64'(done), 64'd0);
        checkOutput({tag, "/idle"}, 64'(busy), 64'd0);
    endtask

    task automatic runOp(input string tag, input int mode, input logic [31:0] av, input logic [31:0] bv);
        applyStimulus(mode, av, bv);
        modelOp(mode, av, bv);
        waitDone(tag, (mode == 1 && bv == 32'd0) ? 0 : 33);
    endtask

    initial begin
        bit sawDone;
        reset      = 1'b0;
        mult_start = 1'b0;
        div_start  = 1'b0;
        a          = '0;
        b          = '0;
        #12;
        checkOutput("reset/hi", 64'(hi), 64'd0);
        checkOutput("reset/lo", 64'(lo), 64'd0);
        checkOutput("reset/flags", 64'({busy, done, div_zero}), 64'd0);
        @(negedge clk);
        reset = 1'b1;

        runOp("mul7xm3", 0, 32'd7, 32'hFFFF_FFFD);
        runOp("mulMinMin", 0, 32'h8000_0000, 32'h8000_0000);
        runOp("mulM1M1", 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        runOp("div100by7", 1, 32'd100, 32'd7);
        runOp("divZero", 1, 32'd55, 32'd0);
        runOp("mulClearsDz", 0, 32'd12345, 32'hFFFF_0001);
        runOp("divM7by2", 1, 32'hFFFF_FFF9, 32'd2);
        runOp("divMinByM1", 1, 32'h8000_0000, 32'hFFFF_FFFF);
        runOp("bothStarts", 2, 32'd1000, 32'd3);

        // A divide request arriving at E10 of a multiply must be dropped.
        applyStimulus(0, 32'hDEAD_BEEF, 32'h0000_1234);
        modelOp(0, 32'hDEAD_BEEF, 32'h0000_1234);
        repeat (9) @(posedge clk);
        @(negedge clk);
        a         = 32'd9;
        b         = 32'd0;
        div_start = 1'b1;
        @(posedge clk);
        #1;
        div_start = 1'b0;
        waitDone("ignoredDiv", 23);

        // Reset asserted in the middle of a multiply abandons it.
        applyStimulus(0, 32'h1234_5678, 32'h8765_4321);
        repeat (14) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        expHi = '0;
        expLo = '0;
        expDz = 1'b0;
        checkOutput("midReset/hi", 64'(hi), 64'd0);
        checkOutput("midReset/lo", 64'(lo), 64'd0);
        checkOutput("midReset/flags", 64'({busy, done, div_zero}), 64'd0);
        @(negedge clk);
        reset   = 1'b1;
        sawDone = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) sawDone = 1'b1;
        end
        checkOutput("midReset/noDone", 64'(sawDone), 64'd0);
        runOp("afterReset", 0, 32'hFFFF_FF00, 32'd77);

        // Randomized operations, including occasional zero divisors and extremes.
        for (int i = 0; i < 24; i++) begin
            int          mode;
            logic [31:0] av;
            logic [31:0] bv;
            mode = int'($urandom_range(0, 2));
            av   = $urandom;
            bv   = $urandom;
            case ($urandom_range(0, 7))
                0:       bv = 32'd0;
                1:       av = 32'h8000_0000;
                2:       bv = 32'hFFFF_FFFF;
                3:       bv = 32'($urandom_range(1, 9));
                default: ;
            endcase
            runOp($sformatf("rand%0d", i), mode, av, bv);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
